// File: rtl/iob_cpu_bus_splitter_if.sv
// PicoRV32-style native memory port between the CPU core and the bus splitter.
// The CPU is the master (issues requests); the splitter is the slave (answers).
interface iob_cpu_bus_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cpu_valid;
    logic                  cpu_instr;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_wstrb;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_ready;

    modport master (
        output cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_rdata, cpu_ready
    );
endinterface

// File: rtl/iob_cpu_bus_splitter.sv
// Registered splitter from the CPU native port to one instruction bus and
// N_DBUS data buses. One transaction in flight, programmable timeout with a
// sticky record of the first failing address.
module iob_cpu_bus_splitter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_DBUS    = 2,
    parameter int TIMEOUT_W = 8,
    localparam int STRB_W   = DATA_W / 8,
    localparam int SEL_W    = (N_DBUS > 1) ? $clog2(N_DBUS) : 1,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    iob_cpu_bus_splitter_if.slave      cpu,
    output logic [REQ_W-1:0]           ibus_req,
    input  logic [RESP_W-1:0]          ibus_resp,
    output logic [N_DBUS*REQ_W-1:0]    dbus_req,
    input  logic [N_DBUS*RESP_W-1:0]   dbus_resp,
    input  logic [TIMEOUT_W-1:0]       timeout_lim,
    output logic                       err,
    output logic [ADDR_W-1:0]          err_addr,
    input  logic                       err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                   tmo_hit;

    // Captured request (valid from the first BUSY cycle on)
    logic                   instr_p1;
    logic [ADDR_W-1:0]      addr_p1;
    logic [DATA_W-1:0]      wdata_p1;
    logic [STRB_W-1:0]      wstrb_p1;
    logic [SEL_W-1:0]       sel_p1;
    // Captured response data, presented in RESP
    logic [DATA_W-1:0]      rdata_p2;

    logic [SEL_W-1:0]       sel_in;
    logic                   sel_bad;
    logic [RESP_W-1:0]      tgt_resp;
    logic                   tgt_ready;
    logic [DATA_W-1:0]      tgt_rdata;
    logic                   capture;
    logic                   rdata_ld;
    logic [DATA_W-1:0]      rdata_nxt;
    logic                   err_set;
    logic [ADDR_W-1:0]      err_addr_nxt;

    // Decode the data-bus channel from the top address bits of the incoming request
    always_comb begin
        sel_in  = (N_DBUS == 1) ? '0 : cpu.cpu_addr[ADDR_W-1 -: SEL_W];
        sel_bad = !cpu.cpu_instr && (32'(sel_in) >= 32'(N_DBUS));
    end

    // Pick the response of the bus owning the transaction; other buses are ignored
    always_comb begin
        tgt_resp = '0;
        if (instr_p1) begin
            tgt_resp = ibus_resp;
        end else begin
            for (int k = 0; k < N_DBUS; k++) begin
                if (sel_p1 == SEL_W'(k)) tgt_resp = dbus_resp[k*RESP_W +: RESP_W];
            end
        end
        tgt_ready = tgt_resp[0];
        tgt_rdata = tgt_resp[RESP_W-1:1];
    end

    // Counter value for this BUSY cycle (saturating) and the limit compare
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
        tmo_hit = (timeout_lim != '0) && (cnt_inc == timeout_lim);
    end

    // Next-state and transaction control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        rdata_ld     = 1'b0;
        rdata_nxt    = '0;
        err_set      = 1'b0;
        err_addr_nxt = addr_p1;
        case (state_q)
            S_IDLE: begin
                if (cpu.cpu_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (sel_bad) begin
                        // Unmapped channel: answer immediately with zero data and flag it
                        state_d      = S_RESP;
                        rdata_ld     = 1'b1;
                        err_set      = 1'b1;
                        err_addr_nxt = cpu.cpu_addr;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (tgt_ready) begin
                    state_d   = S_RESP;
                    rdata_ld  = 1'b1;
                    rdata_nxt = tgt_rdata;
                end else if (tmo_hit) begin
                    state_d  = S_RESP;
                    rdata_ld = 1'b1;
                    err_set  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, timeout counter and sticky error record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end else if (err_set && !err) begin
                err      <= 1'b1;
                err_addr <= err_addr_nxt;
            end
        end
    end

    // Request/response data registers; outputs are gated by state, so no reset needed
    always_ff @(posedge clk) begin
        if (capture) begin
            instr_p1 <= cpu.cpu_instr;
            addr_p1  <= cpu.cpu_addr;
            wdata_p1 <= cpu.cpu_wdata;
            wstrb_p1 <= cpu.cpu_wstrb;
            sel_p1   <= sel_in;
        end
        if (rdata_ld) rdata_p2 <= rdata_nxt;
    end

    // Drive only the owning bus while BUSY; every other request stays all-zero
    always_comb begin
        ibus_req = '0;
        dbus_req = '0;
        if (state_q == S_BUSY) begin
            if (instr_p1) begin
                ibus_req = {1'b1, addr_p1, wdata_p1, wstrb_p1};
            end else begin
                for (int k = 0; k < N_DBUS; k++) begin
                    if (sel_p1 == SEL_W'(k)) dbus_req[k*REQ_W +: REQ_W] = {1'b1, addr_p1, wdata_p1, wstrb_p1};
                end
            end
        end
    end

    assign cpu.cpu_ready = (state_q == S_RESP);
    assign cpu.cpu_rdata = (state_q == S_RESP) ? rdata_p2 : '0;

endmodule

// File: tb/tb_iob_cpu_bus_splitter.sv
// Bench for iob_cpu_bus_splitter: directed scenarios plus randomized
// transactions against a cycle-level transaction model.
module tb_iob_cpu_bus_splitter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int N_DBUS    = 2;
    localparam int TIMEOUT_W = 8;
    localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W    = DATA_W + 1;
    localparam int BUSY_MAX  = 400;

    logic clk = 1'b0;
    logic rst;
    logic [REQ_W-1:0]         ibus_req;
    logic [RESP_W-1:0]        ibus_resp;
    logic [N_DBUS*REQ_W-1:0]  dbus_req;
    logic [N_DBUS*RESP_W-1:0] dbus_resp;
    logic [TIMEOUT_W-1:0]     timeout_lim;
    logic                     err;
    logic [ADDR_W-1:0]        err_addr;
    logic                     err_clr;

    iob_cpu_bus_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

    iob_cpu_bus_splitter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_DBUS(N_DBUS), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .rst(rst), .cpu(cpu_if),
        .ibus_req(ibus_req), .ibus_resp(ibus_resp),
        .dbus_req(dbus_req), .dbus_resp(dbus_resp),
        .timeout_lim(timeout_lim), .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected sticky error record
    logic              exp_err;
    logic [ADDR_W-1:0] exp_err_addr;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ibus"}, 160'(ibus_req), 160'(0));
        chk({tag, "_dbus"}, 160'(dbus_req), 160'(0));
        chk({tag, "_ready"}, 160'(cpu_if.cpu_ready), 160'(0));
        chk({tag, "_rdata"}, 160'(cpu_if.cpu_rdata), 160'(0));
    endtask

    // One CPU transaction. Called just after a rising edge in an IDLE cycle;
    // returns just after the rising edge that starts the following IDLE cycle.
    // wait_n < 0 means the target slave never answers.
    task automatic run_txn(input logic instr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [3:0] wstrb,
                           input int wait_n, input logic [TIMEOUT_W-1:0] lim,
                           input logic [DATA_W-1:0] rd_val, input logic noise,
                           input logic clr);
        logic [REQ_W-1:0]  exp_req;
        logic [DATA_W-1:0] exp_rdata;
        int  tgt;
        int  cyc;
        logic done, tmo, rdy;
        tgt       = instr ? -1 : int'(addr[ADDR_W-1]);
        exp_req   = {1'b1, addr, wdata, wstrb};
        exp_rdata = '0;
        timeout_lim        = lim;
        err_clr            = clr;
        cpu_if.cpu_valid   = 1'b1;
        cpu_if.cpu_instr   = instr;
        cpu_if.cpu_addr    = addr;
        cpu_if.cpu_wdata   = wdata;
        cpu_if.cpu_wstrb   = wstrb;
        @(negedge clk);
        chk_quiet("idle");
        done = 1'b0;
        tmo  = 1'b0;
        cyc  = 0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            rdy = (wait_n >= 0) && (cyc == wait_n + 1);
            ibus_resp = noise ? {DATA_W'($urandom), 1'($urandom)} : '0;
            for (int k = 0; k < N_DBUS; k++)
                dbus_resp[k*RESP_W +: RESP_W] = noise ? {DATA_W'($urandom), 1'($urandom)} : '0;
            if (tgt < 0) ibus_resp = {rdy ? rd_val : ~rd_val, rdy};
            else         dbus_resp[tgt*RESP_W +: RESP_W] = {rdy ? rd_val : ~rd_val, rdy};
            @(negedge clk);
            chk("busy_ibus", 160'(ibus_req), 160'((tgt < 0) ? exp_req : '0));
            for (int k = 0; k < N_DBUS; k++)
                chk($sformatf("busy_dbus%0d", k), 160'(dbus_req[k*REQ_W +: REQ_W]),
                    160'((tgt == k) ? exp_req : '0));
            chk("busy_ready", 160'(cpu_if.cpu_ready), 160'(0));
            if (rdy) begin
                exp_rdata = rd_val;
                done = 1'b1;
            end else if (lim != 0 && cyc == int'(lim)) begin
                tmo  = 1'b1;
                done = 1'b1;
            end else if (cyc >= BUSY_MAX) begin
                chk("busy_bound", 160'(cyc), 160'(0));
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        ibus_resp        = '0;
        dbus_resp        = '0;
        cpu_if.cpu_valid = 1'b0;
        err_clr          = 1'b0;
        if (clr) begin
            exp_err      = 1'b0;
            exp_err_addr = '0;
        end else if (tmo && !exp_err) begin
            exp_err      = 1'b1;
            exp_err_addr = addr;
        end
        @(negedge clk);
        chk("resp_ready", 160'(cpu_if.cpu_ready), 160'(1));
        chk("resp_rdata", 160'(cpu_if.cpu_rdata), 160'(exp_rdata));
        chk("resp_ibus", 160'(ibus_req), 160'(0));
        chk("resp_dbus", 160'(dbus_req), 160'(0));
        chk("err", 160'(err), 160'(exp_err));
        chk("err_addr", 160'(err_addr), 160'(exp_err_addr));
        @(posedge clk); #1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr      = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = '0;
        @(negedge clk);
        chk("clr_err", 160'(err), 160'(0));
        chk("clr_err_addr", 160'(err_addr), 160'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic              ins;
        int                w;
        logic [TIMEOUT_W-1:0] l;

        rst = 1'b1;
        err_clr = 1'b0;
        timeout_lim = '0;
        ibus_resp = '0;
        dbus_resp = '0;
        cpu_if.cpu_valid = 1'b0;
        cpu_if.cpu_instr = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        cpu_if.cpu_wstrb = '0;
        exp_err = 1'b0;
        exp_err_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_err", 160'(err), 160'(0));
        chk("reset_err_addr", 160'(err_addr), 160'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Instruction fetch, zero-wait slave
        run_txn(1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 8'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Data write routed to channel 1, back-to-back
        run_txn(1'b0, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 8'd0, 32'hA5A5_0001, 1'b0, 1'b0);
        // Channel 0 read
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 8'd0, 32'h0BAD_F00D, 1'b1, 1'b0);
        // Five wait states
        run_txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 5, 8'd0, 32'h5555_AAAA, 1'b0, 1'b0);
        // Timeout, then a second timeout that must not overwrite the first address
        run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, -1, 8'd4, 32'h1111_1111, 1'b0, 1'b0);
        run_txn(1'b1, 32'h8000_0040, 32'h0, 4'h0, -1, 8'd3, 32'h2222_2222, 1'b1, 1'b0);
        clear_err();
        // Ready exactly in the limit cycle is a success
        run_txn(1'b0, 32'h8000_0100, 32'hCAFE_0000, 4'hF, 3, 8'd4, 32'h3333_3333, 1'b0, 1'b0);
        // Limit 0 disables the timeout even across a long stall
        run_txn(1'b1, 32'h0000_0200, 32'h0, 4'h0, 300, 8'd0, 32'h4444_4444, 1'b0, 1'b0);
        // Clear wins over a simultaneous new error
        run_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, -1, 8'd2, 32'h0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of BUSY
        run_txn(1'b0, 32'h0000_4000, 32'h0, 4'h0, -1, 8'd1, 32'h0, 1'b0, 1'b0);
        cpu_if.cpu_valid = 1'b1;
        cpu_if.cpu_instr = 1'b1;
        cpu_if.cpu_addr  = 32'h0000_5000;
        timeout_lim      = '0;
        @(posedge clk); #2;
        chk("pre_rst_valid", 160'(ibus_req[REQ_W-1]), 160'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_ibus", 160'(ibus_req), 160'(0));
        chk("rst_async_dbus", 160'(dbus_req), 160'(0));
        chk("rst_async_ready", 160'(cpu_if.cpu_ready), 160'(0));
        cpu_if.cpu_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ready", 160'(cpu_if.cpu_ready), 160'(0));
        chk("rst_err", 160'(err), 160'(0));
        chk("rst_err_addr", 160'(err_addr), 160'(0));
        rst = 1'b0;
        exp_err = 1'b0;
        exp_err_addr = '0;
        @(posedge clk); #1;
        chk("post_rst_ready", 160'(cpu_if.cpu_ready), 160'(0));
        run_txn(1'b0, 32'h8000_0008, 32'h0F0F_0F0F, 4'b1000, 2, 8'd0, 32'h6666_7777, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            ins = 1'($urandom);
            a   = $urandom;
            l   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
            if ($urandom_range(0, 7) == 0) begin
                w = -1;
                if (l == 0) l = 8'($urandom_range(1, 10));
            end else begin
                w = $urandom_range(0, 8);
            end
            if (n == 30) clear_err();
            run_txn(ins, a, $urandom, ins ? 4'h0 : 4'($urandom), w, l, $urandom, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
